onchip_mem_burst_reader: RTL

//  Sequences byte bursts out of the 128K x 8 dual-port on-chip RAM through its second (s2) port.

---
 rtl/onchip_mem_burst_reader_pkg.sv | 12 +
 rtl/onchip_mem_burst_reader_fifo.sv | 53 +++++
 rtl/onchip_mem_burst_reader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/onchip_mem_burst_reader_pkg.sv
// Shared defaults and FSM state encoding for the on-chip RAM burst reader.
package onchip_mem_burst_reader_pkg;

  localparam int unsigned ADDR_W_DEF     = 17;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/onchip_mem_burst_reader_fifo.sv
// Small synchronous first-word-fall-through FIFO holding {byte, last} entries.
module burst_byte_fifo #(
  parameter  int unsigned WIDTH = 9,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == LP_FULL);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rptr];

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

endmodule

// File: rtl/onchip_mem_burst_reader.sv
// Streams byte bursts from the dual-port RAM's second port as a valid/ready
// stream with a last flag; reads are credit-limited by the output buffer.
module onchip_mem_burst_reader
  import onchip_mem_burst_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipsel,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned  CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]  LP_DEPTH = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_left;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_done;

  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W:0]   w_fifo_rdata;
  logic [CW:0]       w_outstanding;
  logic              w_accept;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_pop;
  logic              w_last_pop;

  assign w_accept      = cmd_valid & (r_state == ST_IDLE);
  // Buffered plus in-flight entries bound the reads that may be outstanding.
  assign w_outstanding = {1'b0, w_count} + (CW + 1)'(r_inflight);
  assign w_issue       = (r_state == ST_RUN) & (r_left != '0) & ~w_full
                       & (w_outstanding < LP_DEPTH);
  assign w_issue_last  = w_issue & (r_left == (ADDR_W + 1)'(1));
  assign w_pop         = ~w_empty & out_ready;
  assign w_last_pop    = w_pop & w_fifo_rdata[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_left          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= cmd_base;
            r_left <= cmd_len;
            if (cmd_len == '0) r_done  <= 1'b1;
            else               r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_left <= r_left - (ADDR_W + 1)'(1);
            if (w_issue_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_pop) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM data appears one clock after the address edge; capture it as it arrives.
  burst_byte_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_inflight),
    .push_data ({mem_rdata, r_inflight_last}),
    .pop       (out_ready),
    .pop_data  (w_fifo_rdata),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign cmd_ready   = (r_state == ST_IDLE);
  assign mem_address = r_addr;
  assign mem_chipsel = w_issue;
  assign mem_clken   = w_issue;
  assign mem_write   = 1'b0;
  assign mem_wdata   = '0;
  assign out_valid   = ~w_empty;
  assign out_data    = w_fifo_rdata[DATA_W:1];
  assign out_last    = w_fifo_rdata[0];
  assign busy        = (r_state == ST_RUN) | (r_state == ST_DRAIN);
  assign done        = r_done;

endmodule
